hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the RV32I 5-stage pipeline.
- Watches ID operands, EX load/redirect status and the data-memory handshake.
- Drives the hold and retire (nop-inject) controls of the PC and of the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- A retire input forces 32'h00000033 (add x0,x0,x0) into that register; a hold input keeps the register's contents.

Parameters:
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
MEM_TIMEOUT, 255, max cycles in MEMWAIT before mem_err is raised (1..255).

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous active-high reset.
id_rs1  in  5  rs1 of the instruction in ID.
id_rs2  in  5  rs2 of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_rd  in  5  rd of the instruction in EX.
ex_memread  in  1  EX instruction is a load.
ex_redirect  in  1  EX branch taken, or jal/jalr; PC must load the target.
mem_req  in  1  MEM stage has an outstanding dmem access.
mem_ack  in  1  dmem completes the access this cycle.
pc_hold  out  1  PC keeps its value.
pc_redirect  out  1  PC selects the EX target.
if_id_hold  out  1  if_id keeps its value.
if_id_retire  out  1  if_id loads nop.
id_ex_hold  out  1  id_ex keeps its value.
id_ex_retire  out  1  id_ex loads nop.
ex_mem_hold  out  1  ex_mem keeps its value.
mem_wb_retire  out  1  mem_wb loads nop.
mem_err  out  1  sticky dmem timeout flag.
state  out  2  current FSM state, for debug.

Behaviour:
- State encoding: RUN=0, LUSTALL=1, MEMWAIT=2.
- State, the 3-bit bubble counter, the 8-bit wait counter and mem_err are registered.
- All other outputs are combinational from state and inputs.
- While rst=1:
  - state=RUN, counters=0, mem_err=0.
  - pc_hold=1, if_id_retire=1, id_ex_retire=1, mem_wb_retire=1; every other output 0.
- Hazard terms:
  - memstall = mem_req & ~mem_ack.
  - lu = ex_memread & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority: memstall > ex_redirect > lu.
- RUN:
  - memstall: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_retire all =1; wait counter cleared; next state MEMWAIT.
  - else ex_redirect: pc_redirect, if_id_retire and id_ex_retire all =1; next state RUN. Two wrong-path instructions are squashed.
  - else lu: pc_hold, if_id_hold and id_ex_retire all =1; bubble counter loads LOAD_USE_CYCLES-1. Next state is LUSTALL if LOAD_USE_CYCLES>1, otherwise RUN.
  - else all outputs 0.
- LUSTALL:
  - Same outputs as the lu case; counter decrements each cycle; return to RUN when it reaches 0.
  - memstall while in LUSTALL: go to MEMWAIT. The bubble counter is frozen and resumes afterwards via re-detection of lu.
  - ex_redirect cannot arrive, since a bubble is in EX. If it is asserted anyway, redirect wins and the state returns to RUN.
- MEMWAIT:
  - Freeze outputs, as in the RUN/memstall case, while memstall holds; wait counter increments and saturates at 255.
  - When the counter reaches MEM_TIMEOUT, set mem_err=1. It is sticky until rst. The stall continues regardless.
  - On mem_ack=1: freeze drops in that same cycle, and the RUN rules evaluate in that cycle. A pending ex_redirect or lu is acted on immediately. Next state is per the RUN rules.
  - mem_req dropping without mem_ack: treated as completion, identical to mem_ack.
- Reset asserted mid-stall: immediate return to the reset values above. A pending redirect or bubble is discarded.
- hold and retire are never both 1 on the same register.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_lu_cnt [31:0], perf_flush_cnt [31:0] and perf_mem_cnt [31:0], all reset to 0.
  - perf_lu_cnt increments on each load-use bubble cycle; perf_flush_cnt on each redirect cycle; perf_mem_cnt on each MEMWAIT freeze cycle.
  - Counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, all inputs 0 -> while rst=1: pc_hold=1, if_id_retire=1, id_ex_retire=1, mem_wb_retire=1; first cycle after rst=0: all outputs 0, state=0.
- ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, LOAD_USE_CYCLES=1 -> exactly 1 cycle of pc_hold=1, if_id_hold=1, id_ex_retire=1; the same stimulus with ex_rd=0 gives no stall.
- LOAD_USE_CYCLES=3, lu held -> 3 consecutive stall cycles, state sequence 1,1,0.
- ex_redirect=1 for 1 cycle -> pc_redirect=1, if_id_retire=1, id_ex_retire=1 for that cycle only; redirect with lu also true -> no pc_hold.
- mem_req=1, mem_ack low for 4 cycles then high -> 4 freeze cycles (holds=1, mem_wb_retire=1), state=2; on the ack cycle all freezes are 0 and state returns to 0.
- MEM_TIMEOUT=3, mem_req=1, mem_ack=0 -> mem_err rises after 3 MEMWAIT cycles and stays 1 after the ack; mem_err is cleared only by rst.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl : stall/flush sequencer for the RV32I 5-stage pipeline.       |
// | Optional perf counters enabled by HAZARD_CTRL_PERF_EN.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       pc_hold,
  output logic       pc_redirect,
  output logic       if_id_hold,
  output logic       if_id_retire,
  output logic       id_ex_hold,
  output logic       id_ex_retire,
  output logic       ex_mem_hold,
  output logic       mem_wb_retire,
  output logic       mem_err,
  output logic [1:0] state
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_mem_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam logic [2:0] c_bub_load  = 3'(LOAD_USE_CYCLES - 1);
  localparam logic [7:0] c_timeout   = 8'(MEM_TIMEOUT);
  localparam bit         c_multi_bub = (LOAD_USE_CYCLES > 1);

  state_t     state_q, state_d;
  logic [2:0] bub_q, bub_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;

  logic       w_memstall;
  logic       w_lu;
  logic [7:0] w_wait_inc;

  assign w_memstall = mem_req & ~mem_ack;
  assign w_lu       = ex_memread & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign w_wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

  assign state   = state_q;
  assign mem_err = mem_err_q;

  always_comb begin
    pc_hold       = 1'b0;
    pc_redirect   = 1'b0;
    if_id_hold    = 1'b0;
    if_id_retire  = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_retire  = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_retire = 1'b0;
    state_d       = state_q;
    bub_d         = bub_q;
    wait_d        = wait_q;
    mem_err_d     = mem_err_q;
    if (rst) begin
      pc_hold       = 1'b1;
      if_id_retire  = 1'b1;
      id_ex_retire  = 1'b1;
      mem_wb_retire = 1'b1;
    end else if (w_memstall) begin
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_retire = 1'b1;
      state_d       = MEMWAIT;
      if (state_q == MEMWAIT) begin
        wait_d = w_wait_inc;
        if (w_wait_inc >= c_timeout) mem_err_d = 1'b1;
      end else begin
        wait_d = 8'd0;
      end
    end else if (ex_redirect) begin
      pc_redirect  = 1'b1;
      if_id_retire = 1'b1;
      id_ex_retire = 1'b1;
      state_d      = RUN;
    end else if (state_q == LUSTALL) begin
      // Bubbles continue regardless of lu: the load has already left EX.
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_retire = 1'b1;
      if (bub_q <= 3'd1) begin
        bub_d   = 3'd0;
        state_d = RUN;
      end else begin
        bub_d   = bub_q - 3'd1;
        state_d = LUSTALL;
      end
    end else if (w_lu) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_retire = 1'b1;
      bub_d        = c_bub_load;
      state_d      = c_multi_bub ? LUSTALL : RUN;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      bub_q     <= 3'd0;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bub_q     <= bub_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_lu_cnt_q, perf_lu_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
  logic [31:0] perf_mem_cnt_q, perf_mem_cnt_d;

  // A bubble is the only case with if_id held but id_ex not held.
  always_comb begin
    perf_lu_cnt_d    = perf_lu_cnt_q + {31'd0, if_id_hold & ~id_ex_hold};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, pc_redirect};
    perf_mem_cnt_d   = perf_mem_cnt_q + {31'd0, ex_mem_hold};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt_q    <= 32'd0;
      perf_flush_cnt_q <= 32'd0;
      perf_mem_cnt_q   <= 32'd0;
    end else begin
      perf_lu_cnt_q    <= perf_lu_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
      perf_mem_cnt_q   <= perf_mem_cnt_d;
    end
  end

  assign perf_lu_cnt    = perf_lu_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
  assign perf_mem_cnt   = perf_mem_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl : two hazard_ctrl instances (different bubble/timeout      |
// | settings) driven in lockstep and checked against a behavioural model.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam logic [7:0] P_RST   = 8'b1001_0101;
  localparam logic [7:0] P_STALL = 8'b1010_0100;
  localparam logic [7:0] P_REDIR = 8'b0101_0100;
  localparam logic [7:0] P_FRZ   = 8'b1010_1011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_memread = 1'b0, ex_redirect = 1'b0;
  logic       mem_req = 1'b0, mem_ack = 1'b0;

  // {pc_hold, pc_redirect, if_id_hold, if_id_retire, id_ex_hold, id_ex_retire, ex_mem_hold, mem_wb_retire}
  wire [7:0] act_a, act_b;
  wire [1:0] st_a, st_b;
  wire       err_a, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_CTRL_PERF_EN
  wire [31:0] pl_a, pf_a, pm_a, pl_b, pf_b, pm_b;
`endif

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT(3)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(act_a[7]), .pc_redirect(act_a[6]), .if_id_hold(act_a[5]), .if_id_retire(act_a[4]),
    .id_ex_hold(act_a[3]), .id_ex_retire(act_a[2]), .ex_mem_hold(act_a[1]), .mem_wb_retire(act_a[0]),
    .mem_err(err_a), .state(st_a)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_lu_cnt(pl_a), .perf_flush_cnt(pf_a), .perf_mem_cnt(pm_a)
`endif
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(3), .MEM_TIMEOUT(5)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(act_b[7]), .pc_redirect(act_b[6]), .if_id_hold(act_b[5]), .if_id_retire(act_b[4]),
    .id_ex_hold(act_b[3]), .id_ex_retire(act_b[2]), .ex_mem_hold(act_b[1]), .mem_wb_retire(act_b[0]),
    .mem_err(err_b), .state(st_b)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_lu_cnt(pl_b), .perf_flush_cnt(pf_b), .perf_mem_cnt(pm_b)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bubbles still owed, whether a dmem wait is in progress,
  // how many wait cycles have elapsed, and the sticky error.
  int  m_left [2];
  bit  m_wait [2];
  int  m_cnt  [2];
  bit  m_err  [2];
  int  luc    [2] = '{1, 3};
  int  mto    [2] = '{3, 5};

  logic [7:0] e_out;
  logic [1:0] e_st;
  logic       e_err;
  bit         load_use;

  always @(negedge clk) begin
    load_use = ex_memread && (ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] = 0; m_wait[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      end
      e_st  = m_wait[k] ? 2'd2 : (m_left[k] > 0 ? 2'd1 : 2'd0);
      e_err = m_err[k];
      if (rst) begin
        e_out = P_RST;
      end else if (mem_req && !mem_ack) begin
        e_out = P_FRZ;
        if (m_wait[k]) begin
          m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
          if (m_cnt[k] >= mto[k]) m_err[k] = 1;
        end else begin
          m_cnt[k] = 0;
        end
        m_wait[k] = 1;
        m_left[k] = 0;
      end else begin
        m_wait[k] = 0;
        if (ex_redirect) begin
          e_out = P_REDIR;
          m_left[k] = 0;
        end else if (m_left[k] > 0) begin
          e_out = P_STALL;
          m_left[k] = m_left[k] - 1;
        end else if (load_use) begin
          e_out = P_STALL;
          m_left[k] = luc[k] - 1;
        end else begin
          e_out = 8'd0;
        end
      end
      chk($sformatf("model_out_%0d", k), (k == 0) ? act_a : act_b, e_out);
      chk($sformatf("model_state_%0d", k), {6'd0, (k == 0) ? st_a : st_b}, {6'd0, e_st});
      chk($sformatf("model_err_%0d", k), {7'd0, (k == 0) ? err_a : err_b}, {7'd0, e_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_memread = 0; ex_redirect = 0; mem_req = 0; mem_ack = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step(); step();
    #1;
    chk("rst_out_a", act_a, P_RST);
    chk("rst_state_a", {6'd0, st_a}, 8'd0);
    chk("rst_err_a", {7'd0, err_a}, 8'd0);

    step(); rst = 1'b0; #1;
    chk("idle_out_a", act_a, 8'd0);
    chk("idle_state_a", {6'd0, st_a}, 8'd0);

    // load-use on rs2, one bubble in dut_a, three in dut_b
    step(); ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; #1;
    chk("lu_a", act_a, P_STALL);
    chk("lu_b", act_b, P_STALL);
    step(); clear_in(); #1;
    chk("lu_done_a", act_a, 8'd0);
    chk("lu2_b", act_b, P_STALL);
    chk("lu2_state_b", {6'd0, st_b}, 8'd1);
    step(); #1;
    chk("lu3_b", act_b, P_STALL);
    chk("lu3_state_b", {6'd0, st_b}, 8'd1);
    step(); #1;
    chk("lu_done_b", act_b, 8'd0);
    chk("lu_done_state_b", {6'd0, st_b}, 8'd0);
    step(); ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1; #1;
    chk("lu_x0_a", act_a, 8'd0);

    // redirect, alone and together with a load-use
    step(); clear_in(); ex_redirect = 1; #1;
    chk("redir_a", act_a, P_REDIR);
    step(); ex_redirect = 0; #1;
    chk("redir_end_a", act_a, 8'd0);
    step(); ex_redirect = 1; ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; #1;
    chk("redir_lu_a", act_a, P_REDIR);
    chk("redir_lu_b", act_b, P_REDIR);
    step(); clear_in(); #1;
    chk("redir_lu_after_b", act_b, 8'd0);

    // four freeze cycles then ack; dut_a times out after three MEMWAIT cycles
    step(); mem_req = 1; #1;
    chk("frz1_a", act_a, P_FRZ);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("frz_a", act_a, P_FRZ);
      chk("frz_state_a", {6'd0, st_a}, 8'd2);
    end
    step(); mem_ack = 1; #1;
    chk("ack_out_a", act_a, 8'd0);
    chk("ack_state_a", {6'd0, st_a}, 8'd2);
    chk("timeout_err_a", {7'd0, err_a}, 8'd1);
    chk("no_timeout_b", {7'd0, err_b}, 8'd0);
    step(); mem_req = 0; mem_ack = 0; #1;
    chk("post_ack_state_a", {6'd0, st_a}, 8'd0);
    chk("sticky_err_a", {7'd0, err_a}, 8'd1);
    step(); rst = 1; #1;
    chk("rst_clears_err_a", {7'd0, err_a}, 8'd0);
    chk("rst_mid_a", act_a, P_RST);
    step(); rst = 0;

    // random traffic with small register numbers so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      step();
      rst         = ($urandom_range(0, 199) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 15) == 0);
      if (mem_req && !mem_ack) mem_req = ($urandom_range(0, 9) != 0);
      else                     mem_req = ($urandom_range(0, 3) == 0);
      mem_ack     = mem_req ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
    end

    step(); clear_in();
    step(); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
